// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, fetches one word per instruction over a
// req/ack memory port and hands it to decode through a valid/ready instruction register.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_load,
    output logic [31:0] ir_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] pc,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              load_q, load_d;
    logic              req_q;
    logic              valid_q;
    logic              busy_q;

    // Last wait cycle before a missing ack is declared a fault.
    logic              cnt_expired;
    assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and datapath update; redirect outranks ack, timeout and accept.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (redirect) begin
                    pc_d  = redirect_addr;
                    cnt_d = '0;
                end else if (mem_ack) begin
                    ir_d    = mem_rdata;
                    load_d  = 1'b1;
                    state_d = ISSUE;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ISSUE: begin
                if (redirect) begin
                    pc_d    = redirect_addr;
                    cnt_d   = '0;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; handshake flags are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
            req_q   <= (state_d == FETCH);
            valid_q <= (state_d == ISSUE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = pc_q;
    assign ir_load     = load_q;
    assign ir_data     = ir_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule
